button_debounce: RTL and testbench

//   Input-side counterpart of the LED blinker: samples a raw board pushbutton, synchronises it
//   to the system clock, rejects contact bounce and emits a clean level plus one-cycle

---
 rtl/board_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/button_debounce.sv | 157 +++++++++++++++
 tb/tb_button_debounce.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared Arty Z7-20 board constants, debounce FSM encoding and a us->cycles helper.
// Imported by button_debounce and any other board-input glue.
package board_pkg;

    localparam int unsigned SYS_CLK_HZ = 125_000_000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    // Whole-MHz clocks only: the division is done first to keep 32-bit range.
    function automatic int unsigned us_to_cyc(
        input int unsigned clk_hz,
        input int unsigned us
    );
        return (clk_hz / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs.
// RST_VAL sets the level both flops take during reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= RST_VAL;
            q_o  <= RST_VAL;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Pushbutton synchroniser/debouncer with clean level and press/release pulses.
// Optional long-press pulse enabled by macro BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce
    import board_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = SYS_CLK_HZ,
    parameter int unsigned DEBOUNCE_US     = 10_000,
    parameter int unsigned LONG_PRESS_US   = 1_000_000,
    parameter bit          BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic btn_level_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic long_press_o
);

    localparam int unsigned DB_CYC = us_to_cyc(CLK_FREQ_HZ, DEBOUNCE_US);
    localparam int unsigned LP_CYC = us_to_cyc(CLK_FREQ_HZ, LONG_PRESS_US);
    localparam int unsigned CW     = (DB_CYC > 2) ? $clog2(DB_CYC) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);

    if (DB_CYC < 2) begin : g_db_chk
        $error("button_debounce: DB_CYC must be at least 2");
    end

    if (LP_CYC <= DB_CYC) begin : g_lp_chk
        $error("button_debounce: LP_CYC must exceed DB_CYC");
    end

    logic btn_n;
    logic btn_s;

    assign btn_n = BTN_ACTIVE_HIGH ? btn_i : ~btn_i;

    sync_2ff #(
        .RST_VAL(1'b0)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (btn_n),
        .q_o   (btn_s)
    );

    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign btn_level_o     = level_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned LW = (LP_CYC > 2) ? $clog2(LP_CYC) : 1;
    localparam logic [LW-1:0] LP_LAST = LW'(LP_CYC - 1);

    logic [LW-1:0] lcnt_q;
    logic          long_done_q;
    logic          long_q;
    logic          enter_held;

    // Only a genuine new press restarts the hold timer; release bounce does not.
    assign enter_held = (state_q == PRESS_WAIT) && (state_d == HELD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lcnt_q      <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else if (enter_held) begin
            lcnt_q      <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else if (state_q == HELD || state_q == RELEASE_WAIT) begin
            long_q <= 1'b0;
            if (lcnt_q != LP_LAST) begin
                lcnt_q <= lcnt_q + LW'(1);
            end else if (!long_done_q) begin
                long_q      <= 1'b1;
                long_done_q <= 1'b1;
            end
        end else begin
            long_q <= 1'b0;
        end
    end

    assign long_press_o = long_q;
`else
    assign long_press_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomised and directed bench for button_debounce against a run-length model.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to exercise the long-press pulse.
module tb_button_debounce;

    localparam int DB_CYC = 16;
    localparam int LP_CYC = 64;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic btn_level, press_pulse, release_pulse, long_press;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    button_debounce #(
        .CLK_FREQ_HZ    (1_000_000),
        .DEBOUNCE_US    (16),
        .LONG_PRESS_US  (64),
        .BTN_ACTIVE_HIGH(1'b1)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .btn_i          (btn),
        .btn_level_o    (btn_level),
        .press_pulse_o  (press_pulse),
        .release_pulse_o(release_pulse),
        .long_press_o   (long_press)
    );

    // Model: the level flips once DB_CYC+1 consecutive synchronised samples
    // disagree with it; hold age counts edges spent with the level high.
    typedef struct packed {
        logic s1, s2, level, press, rel, lng, fired;
        int   run;
        int   age;
    } model_t;

    model_t m;

    function automatic model_t step(model_t c, logic b);
        model_t n = c;
        n.s1    = b;
        n.s2    = c.s1;
        n.press = 1'b0;
        n.rel   = 1'b0;
        n.lng   = 1'b0;
        if (c.level) begin
            if (c.age < LP_CYC) n.age = c.age + 1;
            if (n.age == LP_CYC && !c.fired) begin
                n.lng   = LP_EN;
                n.fired = 1'b1;
            end
        end
        if (c.s2 != c.level) begin
            n.run = c.run + 1;
            if (n.run == DB_CYC + 1) begin
                n.run   = 0;
                n.level = c.s2;
                n.press = c.s2;
                n.rel   = ~c.s2;
                if (c.s2) begin
                    n.age   = 0;
                    n.fired = 1'b0;
                end
            end
        end else begin
            n.run = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m, btn);
    end

    wire [3:0] outs  = {btn_level, press_pulse, release_pulse, long_press};
    wire [3:0] exp_o = {m.level, m.press, m.rel, m.lng};

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outs cyc=%0d got=%b want=0000", i, outs);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs !== 4'b0000 || outs !== exp_o) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got=%b want=0000", i, outs);
            end
        end
    endtask

    task automatic test_press();
        int hit = -1;
        int width = 0;
        btn = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs !== exp_o) begin
                n_fail++;
                $display("FAIL press_model cyc=%0d got=%b want=%b", i, outs, exp_o);
            end
            if (press_pulse) begin
                if (hit < 0) hit = i;
                width++;
            end
        end
        n_cmp++;
        if (hit != DB_CYC + 3) begin
            n_fail++;
            $display("FAIL press_latency got=%0d want=%0d", hit, DB_CYC + 3);
        end
        n_cmp++;
        if (width != 1) begin
            n_fail++;
            $display("FAIL press_width got=%0d want=1", width);
        end
        n_cmp++;
        if (btn_level !== 1'b1) begin
            n_fail++;
            $display("FAIL press_level got=%b want=1", btn_level);
        end
    endtask

    task automatic test_release();
        int hit = -1;
        int width = 0;
        btn = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs !== exp_o) begin
                n_fail++;
                $display("FAIL release_model cyc=%0d got=%b want=%b", i, outs, exp_o);
            end
            if (release_pulse) begin
                if (hit < 0) hit = i;
                width++;
            end
        end
        n_cmp++;
        if (hit != DB_CYC + 3 || width != 1) begin
            n_fail++;
            $display("FAIL release_pulse edge=%0d width=%0d want edge=%0d width=1",
                     hit, width, DB_CYC + 3);
        end
        n_cmp++;
        if (btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL release_level got=%b want=0", btn_level);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int hit = -1;
        for (int k = 0; k < 10; k++) begin
            btn = ~k[0];
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                n_cmp++;
                if (outs !== exp_o) begin
                    n_fail++;
                    $display("FAIL bounce_model k=%0d got=%b want=%b", k, outs, exp_o);
                end
                if (press_pulse || release_pulse) pulses++;
            end
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL bounce_quiet got=%0d pulses want=0", pulses);
        end
        btn = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs !== exp_o) begin
                n_fail++;
                $display("FAIL bounce_settle cyc=%0d got=%b want=%b", i, outs, exp_o);
            end
            if (press_pulse && hit < 0) hit = i;
        end
        n_cmp++;
        if (hit != DB_CYC + 3) begin
            n_fail++;
            $display("FAIL bounce_latency got=%0d want=%0d", hit, DB_CYC + 3);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int hit = -1;
        btn = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (press_pulse) pulses++;
        end
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs !== 4'b0000) begin
                n_fail++;
                $display("FAIL midrst_outs cyc=%0d got=%b want=0000", i, outs);
            end
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL midrst_abort got=%0d pulses want=0", pulses);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs !== exp_o) begin
                n_fail++;
                $display("FAIL midrst_model cyc=%0d got=%b want=%b", i, outs, exp_o);
            end
            if (press_pulse && hit < 0) hit = i;
        end
        n_cmp++;
        if (hit != DB_CYC + 3) begin
            n_fail++;
            $display("FAIL midrst_latency got=%0d want=%0d", hit, DB_CYC + 3);
        end
    endtask

    task automatic test_long_press();
        int p = -1;
        int l = -1;
        int n_long = 0;
        int n_press = 0;
        int gap;
        int exp_gap = LP_EN ? LP_CYC : -1;
        int exp_long = LP_EN ? 1 : 0;
        btn = 1'b0;
        for (int i = 0; i < 30; i++) @(negedge clk);
        btn = 1'b1;
        for (int i = 1; i <= 220; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs !== exp_o) begin
                n_fail++;
                $display("FAIL long_model cyc=%0d got=%b want=%b", i, outs, exp_o);
            end
            if (press_pulse) begin
                n_press++;
                p = i;
            end
            if (long_press) begin
                n_long++;
                l = i;
            end
        end
        gap = (l < 0 || p < 0) ? -1 : l - p;
        n_cmp++;
        if (n_press != 1 || n_long != exp_long) begin
            n_fail++;
            $display("FAIL long_count press=%0d long=%0d want press=1 long=%0d",
                     n_press, n_long, exp_long);
        end
        n_cmp++;
        if (gap != exp_gap) begin
            n_fail++;
            $display("FAIL long_gap got=%0d want=%0d", gap, exp_gap);
        end
        btn = 1'b0;
        for (int i = 0; i < 30; i++) @(negedge clk);
    endtask

    task automatic test_random();
        int cyc = 0;
        while (cyc < 4000) begin
            int len = int'($urandom_range(1, 90));
            btn = ~btn;
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                cyc++;
                n_cmp++;
                if (outs !== exp_o) begin
                    n_fail++;
                    $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, outs, exp_o);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_release();
        test_reset_mid();
        test_release();
        test_long_press();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
